// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressable little-endian data memory for the load/store path.
// Each request is one load or store. A misaligned access that crosses a word
// boundary is split into two internal beats. Loads return sign- or
// zero-extended data.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready only in IDLE, rst low)
//   req_we                1 = store, 0 = load
//   req_size              0 byte, 1 half, 2 word, 3 double
//   req_unsigned          zero-extend load result
//   req_addr              64-bit byte address
//   req_wdata             store data, low bytes
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             extended load data (0 for stores and errors)
//   rsp_err               out-of-range address or illegal size
module dmem_ctrl #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [63:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int LANES  = XLEN / 8;
  localparam int OFF_W  = $clog2(LANES);
  localparam int WIDX_W = ADDR_W - OFF_W;
  localparam int WORDS  = 2 ** WIDX_W;

  typedef enum logic [1:0] {IDLE, BEAT2, RESP} state_e;

  state_e state_q, state_d;

  // Storage kept per byte lane so byte enables map onto independent arrays.
  logic [7:0] mem [LANES][WORDS];

  // Request decode
  logic [3:0]         nbytes;
  logic [63:0]        last_addr;
  logic [OFF_W-1:0]   off;
  logic [WIDX_W-1:0]  widx;
  logic               dec_err;
  logic               dec_split;
  logic [2*LANES-1:0] be_full;
  logic [2*XLEN-1:0]  wdata_full;
  logic               accept;

  // Captured request
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [WIDX_W-1:0] widx2_q, widx2_d;
  logic [XLEN-1:0]   wdata2_q, wdata2_d;
  logic [LANES-1:0]  be2_q, be2_d;
  logic [XLEN-1:0]   rd0_q, rd0_d;
  logic [XLEN-1:0]   rd1_q, rd1_d;

  // Memory port
  logic [WIDX_W-1:0] mem_widx;
  logic              mem_we;
  logic [LANES-1:0]  mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rword;

  // Load assembly
  logic [XLEN-1:0] load_raw;
  logic [XLEN-1:0] load_ext;
  logic [3:0]      nb_q;
  logic            sign;

  always_comb begin
    nbytes    = 4'd1 << req_size;
    last_addr = req_addr + 64'(nbytes) - 64'd1;
    off       = req_addr[OFF_W-1:0];
    widx      = req_addr[ADDR_W-1:OFF_W];
    dec_err   = ((req_addr >> ADDR_W) != '0) || ((last_addr >> ADDR_W) != '0) ||
                ((XLEN == 32) && (req_size == 2'd3));
    dec_split = (5'(off) + 5'(nbytes)) > 5'(LANES);
    // Enables and data span two words; the upper half feeds beat 2.
    for (int unsigned i = 0; i < 2 * LANES; i++) begin
      be_full[i] = (i >= 32'(off)) && (i < 32'(off) + 32'(nbytes));
    end
    wdata_full = {{XLEN{1'b0}}, req_wdata} << {off, 3'b000};
    accept     = req_valid && req_ready;
  end

  always_comb begin
    if (state_q == BEAT2) begin
      mem_widx  = widx2_q;
      mem_we    = we_q;
      mem_be    = be2_q;
      mem_wdata = wdata2_q;
    end else begin
      mem_widx  = widx;
      mem_we    = accept && req_we && !dec_err;
      mem_be    = be_full[LANES-1:0];
      mem_wdata = wdata_full[XLEN-1:0];
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      mem_rword[i*8 +: 8] = mem[i][mem_widx];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (mem_we && mem_be[i]) begin
        mem[i][mem_widx] <= mem_wdata[i*8 +: 8];
      end
    end
  end

  always_comb begin
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    err_d    = err_q;
    we_d     = we_q;
    widx2_d  = widx2_q;
    wdata2_d = wdata2_q;
    be2_d    = be2_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    if (accept) begin
      size_d   = req_size;
      uns_d    = req_unsigned;
      off_d    = off;
      err_d    = dec_err;
      we_d     = req_we;
      widx2_d  = widx + WIDX_W'(1);
      wdata2_d = wdata_full[2*XLEN-1:XLEN];
      be2_d    = be_full[2*LANES-1:LANES];
      rd0_d    = mem_rword;
    end
    if (state_q == BEAT2) begin
      rd1_d = mem_rword;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q   <= '0;
      uns_q    <= 1'b0;
      off_q    <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      widx2_q  <= '0;
      wdata2_q <= '0;
      be2_q    <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      err_q    <= err_d;
      we_q     <= we_d;
      widx2_q  <= widx2_d;
      wdata2_q <= wdata2_d;
      be2_q    <= be2_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (!dec_err && dec_split) ? BEAT2 : RESP;
      BEAT2:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load result: shift the two captured words down to the access offset,
  // keep N bytes and fill the rest with the extension byte.
  always_comb begin
    load_raw = XLEN'({rd1_q, rd0_q} >> {off_q, 3'b000});
    nb_q     = 4'd1 << size_q;
    unique case (size_q)
      2'd0:    sign = load_raw[7];
      2'd1:    sign = load_raw[15];
      2'd2:    sign = load_raw[31];
      default: sign = load_raw[XLEN-1];
    endcase
    for (int unsigned i = 0; i < LANES; i++) begin
      load_ext[i*8 +: 8] = (i < 32'(nb_q)) ? load_raw[i*8 +: 8] : {8{sign && !uns_q}};
    end
  end

  // FSM: outputs
  always_comb begin
    req_ready = (state_q == IDLE) && !rst;
    rsp_valid = (state_q == RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !err_q && !we_q) ? load_ext : '0;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_ready;

  logic        v64, rr64, rv64, re64;
  logic [63:0] rd64;
  logic        v32, rr32, rv32, re32;
  logic [31:0] rd32;

  logic        sel32;
  logic        cur_ready, cur_valid, cur_err;
  logic [63:0] cur_rdata;

  assign cur_ready = sel32 ? rr32 : rr64;
  assign cur_valid = sel32 ? rv32 : rv64;
  assign cur_err   = sel32 ? re32 : re64;
  assign cur_rdata = sel32 ? {32'h0, rd32} : rd64;

  dmem_ctrl #(.XLEN(64), .ADDR_W(16)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid(v64), .req_ready(rr64), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv64), .rsp_ready(rsp_ready), .rsp_rdata(rd64), .rsp_err(re64)
  );

  dmem_ctrl #(.XLEN(32), .ADDR_W(16)) u_dut32 (
    .clk(clk), .rst(rst),
    .req_valid(v32), .req_ready(rr32), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .rsp_valid(rv32), .rsp_ready(rsp_ready), .rsp_rdata(rd32), .rsp_err(re32)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input string what, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s/%s: observed 0x%h expected 0x%h", tag, what, obs, expv);
    end
  endtask

  // One request: expectation pushed when driven, popped when the response shows.
  // hold = cycles rsp_ready stays low after rsp_valid appears.
  task automatic op(input string tag, input logic we, input logic [1:0] size,
                    input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                    input logic [63:0] erd, input logic eerr, input int elat, input int hold);
    exp_t e;
    int   n;
    sb.push_back('{rdata: erd, err: eerr, lat: elat});
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    rsp_ready    = (hold == 0);
    if (sel32) v32 = 1'b1; else v64 = 1'b1;
    n = 0;
    while (!cur_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, "accept_wait_ok", 64'(n < 20), 64'd1);
    @(posedge clk); #1;
    v32 = 1'b0;
    v64 = 1'b0;
    n = 1;
    while (!cur_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    chk(tag, "latency", 64'(n), 64'(e.lat));
    chk(tag, "rdata", cur_rdata, e.rdata);
    chk(tag, "err", 64'(cur_err), 64'(e.err));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk(tag, "held_valid", 64'(cur_valid), 64'd1);
      chk(tag, "held_rdata", cur_rdata, e.rdata);
      chk(tag, "held_ready", 64'(cur_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk(tag, "valid_after_hs", 64'(cur_valid), 64'd0);
    chk(tag, "ready_after_hs", 64'(cur_ready), 64'd1);
  endtask

  initial begin
    rst          = 1'b1;
    v64          = 1'b0;
    v32          = 1'b0;
    sel32        = 1'b0;
    rsp_ready    = 1'b1;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;

    // Reset state
    @(posedge clk); #1;
    chk("reset", "req_ready", 64'(rr64), 64'd0);
    chk("reset", "rsp_valid", 64'(rv64), 64'd0);
    chk("reset", "rsp_rdata", rd64, 64'd0);
    chk("reset", "rsp_err", 64'(re64), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("reset", "ready_after", 64'(rr64), 64'd1);

    // Aligned double store/load
    op("sd100", 1, 3, 0, 64'h100, 64'h0123456789ABCDEF, 64'h0, 0, 1, 0);
    op("ld100", 0, 3, 0, 64'h100, 64'h0, 64'h0123456789ABCDEF, 0, 1, 0);

    // Byte store and extension
    op("sb103",  1, 0, 0, 64'h103, 64'h80, 64'h0, 0, 1, 0);
    op("lb103",  0, 0, 0, 64'h103, 64'h0, 64'hFFFFFFFFFFFFFF80, 0, 1, 0);
    op("lbu103", 0, 0, 1, 64'h103, 64'h0, 64'h0000000000000080, 0, 1, 0);
    op("ld100b", 0, 3, 0, 64'h100, 64'h0, 64'h0123456780ABCDEF, 0, 1, 0);
    op("lh102",  0, 1, 0, 64'h102, 64'h0, 64'hFFFFFFFFFFFF80AB, 0, 1, 0);

    // Split word across 0x1FF/0x200
    op("sd1f8",  1, 3, 0, 64'h1F8, 64'h0, 64'h0, 0, 1, 0);
    op("sd200",  1, 3, 0, 64'h200, 64'h0, 64'h0, 0, 1, 0);
    op("sw1fe",  1, 2, 0, 64'h1FE, 64'hDEADBEEF, 64'h0, 0, 2, 0);
    op("lw1fe",  0, 2, 0, 64'h1FE, 64'h0, 64'hFFFFFFFFDEADBEEF, 0, 2, 0);
    op("lwu1fe", 0, 2, 1, 64'h1FE, 64'h0, 64'h00000000DEADBEEF, 0, 2, 0);
    op("ld1f8",  0, 3, 0, 64'h1F8, 64'h0, 64'hBEEF000000000000, 0, 1, 0);
    op("ld200",  0, 3, 0, 64'h200, 64'h0, 64'h000000000000DEAD, 0, 1, 0);

    // Backpressure
    op("ld_bp", 0, 3, 0, 64'h100, 64'h0, 64'h0123456780ABCDEF, 0, 1, 5);

    // Range errors
    op("sdfff8",  1, 3, 0, 64'hFFF8, 64'h5555AAAA5555AAAA, 64'h0, 0, 1, 0);
    op("ld10000", 0, 3, 0, 64'h10000, 64'h0, 64'h0, 1, 1, 0);
    op("sdfffc",  1, 3, 0, 64'hFFFC, 64'h0123456789ABCDEF, 64'h0, 1, 1, 0);
    op("ldfff8",  0, 3, 0, 64'hFFF8, 64'h0, 64'h5555AAAA5555AAAA, 0, 1, 0);
    op("lhffff",  0, 1, 0, 64'hFFFF, 64'h0, 64'h0, 1, 1, 0);
    op("lbuffff", 0, 0, 1, 64'hFFFF, 64'h0, 64'h55, 0, 1, 0);

    // Reset during beat 2 of a split store
    op("sd2f8", 1, 3, 0, 64'h2F8, 64'h0F0E0D0C0B0A0908, 64'h0, 0, 1, 0);
    op("sd300", 1, 3, 0, 64'h300, 64'h1716151413121110, 64'h0, 0, 1, 0);
    req_we       = 1'b1;
    req_size     = 2'd3;
    req_unsigned = 1'b0;
    req_addr     = 64'h2FC;
    req_wdata    = 64'h1122334455667788;
    v64          = 1'b1;
    chk("rst_split", "ready_before", 64'(rr64), 64'd1);
    @(posedge clk); #1;
    v64 = 1'b0;
    chk("rst_split", "beat2_no_valid", 64'(rv64), 64'd0);
    chk("rst_split", "beat2_not_ready", 64'(rr64), 64'd0);
    rst = 1'b1;
    #1;
    chk("rst_split", "ready_in_rst", 64'(rr64), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_split", "ready_after", 64'(rr64), 64'd1);
    chk("rst_split", "no_valid", 64'(rv64), 64'd0);
    @(posedge clk); #1;
    chk("rst_split", "still_no_valid", 64'(rv64), 64'd0);
    op("ld2f8", 0, 3, 0, 64'h2F8, 64'h0, 64'h556677880B0A0908, 0, 1, 0);
    op("ld300", 0, 3, 0, 64'h300, 64'h0, 64'h1716151413121110, 0, 1, 0);

    // 32-bit build
    sel32 = 1'b1;
    op("x32_ld",  0, 3, 0, 64'h0, 64'h0, 64'h0, 1, 1, 0);
    op("x32_sw6", 1, 2, 0, 64'h6, 64'hCAFEF00D, 64'h0, 0, 2, 0);
    op("x32_lw6", 0, 2, 0, 64'h6, 64'h0, 64'hCAFEF00D, 0, 2, 0);
    op("x32_lb9", 0, 0, 0, 64'h9, 64'h0, 64'hFFFFFFCA, 0, 1, 0);
    op("x32_lhu8", 0, 1, 1, 64'h8, 64'h0, 64'h0000CAFE, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised, byte-addressable data-memory block for the RV64I core's load/store path. Holds a little-endian memory array of XLEN-bit words and services one load or store per handshake. Supports byte/half/word/double sizes, sign/zero extension on loads, and misaligned accesses that straddle a word boundary, which are split into two internal beats. Sits between the MEM stage and on-chip storage, with valid/ready handshakes on both the request and response sides.

## Interface
Parameters:
- XLEN, 64: data width in bits; 32 or 64 only. LANES = XLEN/8 bytes per word.
- ADDR_W, 16: byte-address bits; capacity 2^ADDR_W bytes, i.e. 2^ADDR_W/LANES words.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; 1 only in IDLE with rst low.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  load zero-extends when 1; ignored for stores.
- req_addr  in  64  byte address.
- req_wdata  in  XLEN  store data, in the low bytes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  request was out of range or had an illegal size.

## Operation
- Accept occurs when req_valid & req_ready. The request is captured, and the block never reads req_* after the accept edge.
- N = 2^req_size bytes; last byte = addr+N-1; off = addr mod LANES.
- Error when any of the following holds:
  - req_addr ≥ 2^ADDR_W.
  - last byte ≥ 2^ADDR_W. No wrap-around.
  - req_size = 3 with XLEN = 32.
- On error: no memory write, rsp_err = 1, rsp_rdata = 0.
- Single beat: off + N ≤ LANES. Word index = addr >> log2(LANES). Store enables byte lanes off..off+N-1.
- Split: off + N > LANES. Beat 1 covers word W, lanes off..LANES-1. Beat 2 covers word W+1, lanes 0..(off+N-LANES-1). Bytes stay little-endian across the boundary.
- Load result: N bytes assembled little-endian, then sign-extended (req_unsigned = 0) or zero-extended to XLEN. Size 3 has no extension.
- States:
  - IDLE: accept; a split goes to BEAT2, all other requests go to RESP.
  - BEAT2: access the second word, then go to RESP.
  - RESP: rsp_valid = 1; go to IDLE on rsp_ready.
- Stores return rsp_valid with rsp_rdata = 0 as a completion signal.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0. req_ready is 0 while rst = 1.
- The memory array is written and read synchronously on the rising edge.
- Single beat, or error, accepted at edge T: access at edge T; rsp_valid = 1 from cycle T+1.
- Split accepted at edge T: beat 1 at edge T, beat 2 at edge T+1; rsp_valid = 1 from cycle T+2.
- rsp_rdata and rsp_err stay stable while rsp_valid & !rsp_ready.
- req_ready = 0 in BEAT2 and RESP. The next accept is possible in the cycle after the response handshake, so peak throughput is one single-beat op per 2 cycles.
- A load issued after a store returns the stored data; there are no stale reads.
- Reset during BEAT2 of a store: the beat-1 bytes remain written, beat 2 is dropped, and no response is issued.
- Reset during RESP: the response is discarded.

## Test plan
1. XLEN=64, ADDR_W=16. SD 0x0123456789ABCDEF @0x100, then LD @0x100 -> rdata 0x0123456789ABCDEF, rsp_valid exactly 1 cycle after each accept, rsp_err 0.
2. After scenario 1:
   - SB 0x80 @0x103.
   - LB @0x103 -> 0xFFFFFFFFFFFFFF80.
   - LBU @0x103 -> 0x0000000000000080.
   - LD @0x100 -> 0x0123456780ABCDEF.
   - LH @0x102 -> 0xFFFFFFFFFFFF80AB.
3. Misaligned split:
   - SW 0xDEADBEEF @0x1FE -> bytes 0x1FE=EF, 0x1FF=BE, 0x200=AD, 0x201=DE.
   - LW @0x1FE -> 0xFFFFFFFFDEADBEEF.
   - LWU @0x1FE -> 0x00000000DEADBEEF.
   - Response arrives 2 cycles after accept; LD @0x1F8 upper bytes show only BE, EF changed.
4. Backpressure: LD with rsp_ready held 0 for 5 cycles -> rsp_valid and rdata held constant, req_ready 0, no second accept. Raise rsp_ready -> handshake, req_ready 1 next cycle.
5. Errors:
   - LD @0x10000 -> rsp_err 1, rdata 0.
   - SD @0xFFFC -> rsp_err 1, and LD @0xFFF8 data is unchanged.
   - XLEN=32 build, size 3 -> rsp_err 1.
6. Reset mid-split: SD 0x1122334455667788 @0x2FC, assert rst in the BEAT2 cycle -> 0x2FC..0x2FF = 88,77,66,55, 0x300..0x303 unchanged, rsp_valid 0, req_ready 1 after rst falls.
